// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register: decode, immediate extension, operand forwarding, valid/ready handshake.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB operand forwarding; undefined uses held register-file data.
module id_ex_stage #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   flush,
   input  logic [5:0]             opcode,
   input  logic [5:0]             funct,
   input  logic [4:0]             rs_addr,
   input  logic [4:0]             rt_addr,
   input  logic [4:0]             rd_addr,
   input  logic [31:0]            rs_data,
   input  logic [31:0]            rt_data,
   input  logic [15:0]            imm16,
   input  logic                   fwd_exm_we,
   input  logic [4:0]             fwd_exm_reg,
   input  logic [31:0]            fwd_exm_data,
   input  logic                   fwd_mwb_we,
   input  logic [4:0]             fwd_mwb_reg,
   input  logic [31:0]            fwd_mwb_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            alu_a,
   output logic [31:0]            alu_b,
   output logic [3:0]             alu_ctrl,
   output logic [31:0]            store_data,
   output logic [4:0]             wb_reg,
   output logic                   reg_write,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   is_branch_eq,
   output logic                   is_branch_ne,
   output logic                   illegal,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

   logic [3:0]  d_ctrl;
   logic        d_use_imm;
   logic        d_sext;
   logic [4:0]  d_wb;
   logic        d_rw;
   logic        d_mr;
   logic        d_mw;
   logic        d_beq;
   logic        d_bne;
   logic        d_ill;
   logic [31:0] d_imm;

   logic [4:0]  rs_addr_q;
   logic [4:0]  rt_addr_q;
   logic [31:0] rs_data_q;
   logic [31:0] rt_data_q;
   logic [31:0] imm_q;
   logic        use_imm_q;
   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;
   logic        load;

   always_comb begin
      d_ctrl    = ALU_AND;
      d_use_imm = 1'b0;
      d_sext    = 1'b0;
      d_wb      = 5'd0;
      d_rw      = 1'b0;
      d_mr      = 1'b0;
      d_mw      = 1'b0;
      d_beq     = 1'b0;
      d_bne     = 1'b0;
      d_ill     = 1'b0;
      case (opcode)
         6'h00: begin
            d_wb = rd_addr;
            d_rw = 1'b1;
            case (funct)
               6'h20, 6'h21: d_ctrl = ALU_ADD;
               6'h22, 6'h23: d_ctrl = ALU_SUB;
               6'h24:        d_ctrl = ALU_AND;
               6'h25:        d_ctrl = ALU_OR;
               6'h27:        d_ctrl = ALU_NOR;
               6'h2A:        d_ctrl = ALU_SLT;
               default:      d_ill  = 1'b1;
            endcase
         end
         6'h08, 6'h09: begin
            d_ctrl = ALU_ADD; d_use_imm = 1'b1; d_sext = 1'b1; d_wb = rt_addr; d_rw = 1'b1;
         end
         6'h0A: begin
            d_ctrl = ALU_SLT; d_use_imm = 1'b1; d_sext = 1'b1; d_wb = rt_addr; d_rw = 1'b1;
         end
         6'h0C: begin
            d_ctrl = ALU_AND; d_use_imm = 1'b1; d_wb = rt_addr; d_rw = 1'b1;
         end
         6'h0D: begin
            d_ctrl = ALU_OR; d_use_imm = 1'b1; d_wb = rt_addr; d_rw = 1'b1;
         end
         6'h23: begin
            d_ctrl = ALU_ADD; d_use_imm = 1'b1; d_sext = 1'b1; d_wb = rt_addr; d_rw = 1'b1; d_mr = 1'b1;
         end
         6'h2B: begin
            d_ctrl = ALU_ADD; d_use_imm = 1'b1; d_sext = 1'b1; d_mw = 1'b1;
         end
         6'h04: begin
            d_ctrl = ALU_SUB; d_beq = 1'b1;
         end
         6'h05: begin
            d_ctrl = ALU_SUB; d_bne = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
      // An undecodable instruction must not cause any architectural side effect downstream.
      if (d_ill) begin
         d_ctrl    = ALU_AND;
         d_use_imm = 1'b0;
         d_wb      = 5'd0;
         d_rw      = 1'b0;
         d_mr      = 1'b0;
         d_mw      = 1'b0;
         d_beq     = 1'b0;
         d_bne     = 1'b0;
      end
   end

   assign d_imm    = d_sext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         alu_ctrl     <= ALU_AND;
         wb_reg       <= 5'd0;
         reg_write    <= 1'b0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         is_branch_eq <= 1'b0;
         is_branch_ne <= 1'b0;
         illegal      <= 1'b0;
         rs_addr_q    <= 5'd0;
         rt_addr_q    <= 5'd0;
         rs_data_q    <= 32'h0;
         rt_data_q    <= 32'h0;
         imm_q        <= 32'h0;
         use_imm_q    <= 1'b0;
         stall_cycles <= '0;
      end else begin
         out_valid <= flush ? 1'b0 : (in_ready ? in_valid : 1'b1);
         if (load) begin
            alu_ctrl     <= d_ctrl;
            wb_reg       <= d_wb;
            reg_write    <= d_rw;
            mem_read     <= d_mr;
            mem_write    <= d_mw;
            is_branch_eq <= d_beq;
            is_branch_ne <= d_bne;
            illegal      <= d_ill;
            rs_addr_q    <= rs_addr;
            rt_addr_q    <= rt_addr;
            rs_data_q    <= rs_data;
            rt_data_q    <= rt_data;
            imm_q        <= d_imm;
            use_imm_q    <= d_use_imm;
         end
         if (out_valid && !out_ready && (stall_cycles != STALL_MAX))
            stall_cycles <= stall_cycles + STALL_ONE;
      end
   end

`ifdef ID_EX_FWD_EN
   // Youngest producer wins; $0 is hard-wired so never takes a bypass.
   function automatic logic [31:0] fwd_pick(input logic [4:0] r, input logic [31:0] held,
                                            input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                            input logic mw, input logic [4:0] mr, input logic [31:0] md);
      logic [31:0] v;
      v = held;
      if (r != 5'd0) begin
         if (ew && (er == r))
            v = ed;
         else if (mw && (mr == r))
            v = md;
      end
      return v;
   endfunction

   assign rs_fwd = fwd_pick(rs_addr_q, rs_data_q, fwd_exm_we, fwd_exm_reg, fwd_exm_data,
                            fwd_mwb_we, fwd_mwb_reg, fwd_mwb_data);
   assign rt_fwd = fwd_pick(rt_addr_q, rt_data_q, fwd_exm_we, fwd_exm_reg, fwd_exm_data,
                            fwd_mwb_we, fwd_mwb_reg, fwd_mwb_data);
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_exm_we, fwd_exm_reg, fwd_exm_data, fwd_mwb_we, fwd_mwb_reg,
                         fwd_mwb_data, rs_addr_q, rt_addr_q};
   assign rs_fwd = rs_data_q;
   assign rt_fwd = rt_data_q;
`endif

   assign alu_a      = rs_fwd;
   assign alu_b      = use_imm_q ? imm_q : rt_fwd;
   assign store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  rd_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [15:0] imm16;
   logic        fwd_exm_we;
   logic [4:0]  fwd_exm_reg;
   logic [31:0] fwd_exm_data;
   logic        fwd_mwb_we;
   logic [4:0]  fwd_mwb_reg;
   logic [31:0] fwd_mwb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] store_data;
   logic [4:0]  wb_reg;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        is_branch_eq;
   logic        is_branch_ne;
   logic        illegal;
   logic [15:0] stall_cycles;

   id_ex_stage #(.STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
      .fwd_exm_we(fwd_exm_we), .fwd_exm_reg(fwd_exm_reg), .fwd_exm_data(fwd_exm_data),
      .fwd_mwb_we(fwd_mwb_we), .fwd_mwb_reg(fwd_mwb_reg), .fwd_mwb_data(fwd_mwb_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .store_data(store_data), .wb_reg(wb_reg), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .is_branch_eq(is_branch_eq),
      .is_branch_ne(is_branch_ne), .illegal(illegal), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [15:0] imm;
      logic        ew;
      logic [4:0]  er;
      logic [31:0] ed;
      logic        mw;
      logic [4:0]  mr;
      logic [31:0] md;
      logic        chk;
      logic [3:0]  ctrl;
      logic [4:0]  wb;
      logic [5:0]  flags;   // {reg_write, mem_read, mem_write, beq, bne, illegal}
      logic [31:0] a_f;
      logic [31:0] b_f;
      logic [31:0] sd_f;
      logic [31:0] a_n;
      logic [31:0] b_n;
      logic [31:0] sd_n;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      opcode = v.op; funct = v.fn; rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
      rs_data = v.rsd; rt_data = v.rtd; imm16 = v.imm;
      fwd_exm_we = v.ew; fwd_exm_reg = v.er; fwd_exm_data = v.ed;
      fwd_mwb_we = v.mw; fwd_mwb_reg = v.mr; fwd_mwb_data = v.md;
   endtask

   function automatic logic [5:0] flags_now();
      return {reg_write, mem_read, mem_write, is_branch_eq, is_branch_ne, illegal};
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           op     fn     rs  rt  rd  rsd           rtd           imm       ew er ed            mw mr md            chk ctrl  wb  flags      a_f           b_f           sd_f          a_n           b_n           sd_n
      vecs[0]  = '{6'h00, 6'h2A, 1,  2,  7,  32'h5,        32'hFFFFFFFD, 16'h3A2A, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h7, 7,  6'b100000, 32'h5,        32'hFFFFFFFD, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFD, 32'hFFFFFFFD};
      vecs[1]  = '{6'h00, 6'h20, 8,  9,  10, 32'h10,       32'h20,       16'h5020, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h2, 10, 6'b100000, 32'h10,       32'h20,       32'h20,       32'h10,       32'h20,       32'h20};
      vecs[2]  = '{6'h00, 6'h21, 8,  9,  11, 32'h11,       32'h21,       16'h5821, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h2, 11, 6'b100000, 32'h11,       32'h21,       32'h21,       32'h11,       32'h21,       32'h21};
      vecs[3]  = '{6'h00, 6'h22, 8,  9,  12, 32'h12,       32'h22,       16'h6022, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h6, 12, 6'b100000, 32'h12,       32'h22,       32'h22,       32'h12,       32'h22,       32'h22};
      vecs[4]  = '{6'h00, 6'h23, 8,  9,  13, 32'h13,       32'h23,       16'h6823, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h6, 13, 6'b100000, 32'h13,       32'h23,       32'h23,       32'h13,       32'h23,       32'h23};
      vecs[5]  = '{6'h00, 6'h24, 8,  9,  14, 32'h14,       32'h24,       16'h7024, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h0, 14, 6'b100000, 32'h14,       32'h24,       32'h24,       32'h14,       32'h24,       32'h24};
      vecs[6]  = '{6'h00, 6'h25, 8,  9,  15, 32'h15,       32'h25,       16'h7825, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h1, 15, 6'b100000, 32'h15,       32'h25,       32'h25,       32'h15,       32'h25,       32'h25};
      vecs[7]  = '{6'h00, 6'h27, 8,  9,  16, 32'h16,       32'h27,       16'h8027, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'hC, 16, 6'b100000, 32'h16,       32'h27,       32'h27,       32'h16,       32'h27,       32'h27};
      vecs[8]  = '{6'h00, 6'h26, 8,  9,  17, 32'h17,       32'h26,       16'h8826, 0, 0, 32'h0,        0, 0, 32'h0,        0, 4'h0, 0,  6'b000001, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
      vecs[9]  = '{6'h0D, 6'h01, 1,  4,  0,  32'h12,       32'h34,       16'h8001, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h1, 4,  6'b100000, 32'h12,       32'h00008001, 32'h34,       32'h12,       32'h00008001, 32'h34};
      vecs[10] = '{6'h08, 6'h01, 1,  5,  0,  32'h12,       32'h34,       16'h8001, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h2, 5,  6'b100000, 32'h12,       32'hFFFF8001, 32'h34,       32'h12,       32'hFFFF8001, 32'h34};
      vecs[11] = '{6'h09, 6'h3F, 1,  6,  0,  32'h12,       32'h34,       16'h7FFF, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h2, 6,  6'b100000, 32'h12,       32'h00007FFF, 32'h34,       32'h12,       32'h00007FFF, 32'h34};
      vecs[12] = '{6'h0A, 6'h3F, 1,  7,  0,  32'h12,       32'h34,       16'hFFFF, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h7, 7,  6'b100000, 32'h12,       32'hFFFFFFFF, 32'h34,       32'h12,       32'hFFFFFFFF, 32'h34};
      vecs[13] = '{6'h0C, 6'h30, 1,  8,  0,  32'h12,       32'h34,       16'hF0F0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h0, 8,  6'b100000, 32'h12,       32'h0000F0F0, 32'h34,       32'h12,       32'h0000F0F0, 32'h34};
      vecs[14] = '{6'h23, 6'h3C, 1,  9,  0,  32'h12,       32'h34,       16'hFFFC, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h2, 9,  6'b110000, 32'h12,       32'hFFFFFFFC, 32'h34,       32'h12,       32'hFFFFFFFC, 32'h34};
      vecs[15] = '{6'h2B, 6'h08, 1,  10, 0,  32'h100,      32'h55,       16'h0008, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h2, 0,  6'b001000, 32'h100,      32'h8,        32'h55,       32'h100,      32'h8,        32'h55};
      vecs[16] = '{6'h04, 6'h04, 1,  2,  0,  32'h7,        32'h7,        16'h0004, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h6, 0,  6'b000100, 32'h7,        32'h7,        32'h7,        32'h7,        32'h7,        32'h7};
      vecs[17] = '{6'h05, 6'h04, 1,  2,  0,  32'h7,        32'h9,        16'hFFF4, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4'h6, 0,  6'b000010, 32'h7,        32'h9,        32'h9,        32'h7,        32'h9,        32'h9};
      vecs[18] = '{6'h3F, 6'h20, 1,  2,  3,  32'h7,        32'h9,        16'h1820, 0, 0, 32'h0,        0, 0, 32'h0,        0, 4'h0, 0,  6'b000001, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
      vecs[19] = '{6'h00, 6'h20, 3,  4,  5,  32'h1,        32'h2,        16'h2820, 1, 3, 32'hAA,       1, 3, 32'hBB,       1, 4'h2, 5,  6'b100000, 32'hAA,       32'h2,        32'h2,        32'h1,        32'h2,        32'h2};
      vecs[20] = '{6'h00, 6'h20, 0,  0,  6,  32'h11,       32'h22,       16'h3020, 1, 0, 32'hAA,       1, 0, 32'hBB,       1, 4'h2, 6,  6'b100000, 32'h11,       32'h22,       32'h22,       32'h11,       32'h22,       32'h22};
      vecs[21] = '{6'h00, 6'h20, 6,  9,  1,  32'h66,       32'h99,       16'h0820, 0, 6, 32'hAA,       1, 9, 32'hCC,       1, 4'h2, 1,  6'b100000, 32'h66,       32'hCC,       32'hCC,       32'h66,       32'h99,       32'h99};
      vecs[22] = '{6'h2B, 6'h10, 2,  5,  0,  32'h1000,     32'h55,       16'h0010, 1, 5, 32'hDEAD,     1, 5, 32'hBEEF,     1, 4'h2, 0,  6'b001000, 32'h1000,     32'h10,       32'hDEAD,     32'h1000,     32'h10,       32'h55};
      vecs[23] = '{6'h00, 6'h20, 7,  8,  2,  32'h70,       32'h80,       16'h1020, 1, 8, 32'hE8,       1, 7, 32'hF7,       1, 4'h2, 2,  6'b100000, 32'hF7,       32'hE8,       32'hE8,       32'h70,       32'h80,       32'h80};

      // reset with random inputs
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'($urandom); opcode = 6'($urandom); funct = 6'($urandom);
      rs_addr = 5'($urandom); rt_addr = 5'($urandom); rd_addr = 5'($urandom);
      rs_data = $urandom; rt_data = $urandom; imm16 = 16'($urandom);
      fwd_exm_we = 1'($urandom); fwd_exm_reg = 5'($urandom); fwd_exm_data = $urandom;
      fwd_mwb_we = 1'($urandom); fwd_mwb_reg = 5'($urandom); fwd_mwb_data = $urandom;
      repeat (2) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'h0);
      chk("rst alu_ctrl", 32'(alu_ctrl), 32'h0);
      chk("rst stall", 32'(stall_cycles), 32'h0);
      chk("rst in_ready", 32'(in_ready), 32'h1);
      chk("rst flags", 32'(flags_now()), 32'h0);

      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive_vec(vecs[i]);
         @(negedge clk);
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
         chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
         chk($sformatf("v%0d wb_reg", i), 32'(wb_reg), 32'(vecs[i].wb));
         chk($sformatf("v%0d flags", i), 32'(flags_now()), 32'(vecs[i].flags));
         if (vecs[i].chk) begin
            chk($sformatf("v%0d alu_a", i), alu_a, FWD ? vecs[i].a_f : vecs[i].a_n);
            chk($sformatf("v%0d alu_b", i), alu_b, FWD ? vecs[i].b_f : vecs[i].b_n);
            chk($sformatf("v%0d store_data", i), store_data, FWD ? vecs[i].sd_f : vecs[i].sd_n);
         end
      end
      chk("no stall with ready", 32'(stall_cycles), 32'h0);

      // drain with no new instruction
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain out_valid", 32'(out_valid), 32'h0);

      // back-pressure hold, forwarding re-evaluated during hold, then flush while stalled
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      opcode = 6'h00; funct = 6'h22; rs_addr = 5'd3; rt_addr = 5'd4; rd_addr = 5'd9;
      rs_data = 32'h100; rt_data = 32'h200; imm16 = 16'h4822;
      fwd_exm_we = 1'b0; fwd_mwb_we = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("hold load out_valid", 32'(out_valid), 32'h1);
      chk("hold in_ready", 32'(in_ready), 32'h0);
      chk("hold stall start", 32'(stall_cycles), 32'h0);
      opcode = 6'h0D; rs_data = 32'hFFFF; rd_addr = 5'd1; imm16 = 16'h1234;
      fwd_exm_we = 1'b1; fwd_exm_reg = 5'd3; fwd_exm_data = 32'h77;
      repeat (4) @(negedge clk);
      chk("hold stall4", 32'(stall_cycles), 32'h4);
      chk("hold out_valid", 32'(out_valid), 32'h1);
      chk("hold alu_ctrl", 32'(alu_ctrl), 32'h6);
      chk("hold wb_reg", 32'(wb_reg), 32'h9);
      chk("hold alu_a", alu_a, FWD ? 32'h77 : 32'h100);
      chk("hold alu_b", alu_b, 32'h200);
      flush = 1'b1;
      @(negedge clk);
      chk("flush stalled out_valid", 32'(out_valid), 32'h0);
      chk("flush stall5", 32'(stall_cycles), 32'h5);
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("idle stall kept", 32'(stall_cycles), 32'h5);
      chk("idle in_ready", 32'(in_ready), 32'h1);

      // flush together with in_valid, from both full and empty
      fwd_exm_we = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      opcode = 6'h00; funct = 6'h25; rd_addr = 5'd21;
      @(negedge clk);
      chk("reload out_valid", 32'(out_valid), 32'h1);
      chk("reload alu_ctrl", 32'(alu_ctrl), 32'h1);
      flush = 1'b1; funct = 6'h24;
      @(negedge clk);
      chk("flush+in_valid full", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("flush+in_valid empty", 32'(out_valid), 32'h0);
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("after flush idle", 32'(out_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
